// File: rtl/mul16_seq.sv
// Sequential 16x16 shift-and-add multiplier, product modulo 2^16.
// One step per clock through a single shared ripple adder.

module add16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [15:0] o_sum
);

   logic [15:0] w_c;

   assign w_c[0] = 1'b0;

   for (genvar i = 0; i < 16; i++) begin : g_fa
      assign o_sum[i] = i_a[i] ^ i_b[i] ^ w_c[i];
      if (i < 15) begin : g_carry
         assign w_c[i+1] = (i_a[i] & i_b[i])
                         | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
   end

endmodule

module mul16_seq #(
   parameter bit EARLY_EXIT = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic        busy,
   output logic        done,
   output logic [15:0] out
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_acc;
   logic [15:0] r_mcand;
   logic [15:0] r_mplr;
   logic [4:0]  r_cnt;
   logic [15:0] r_out;

   logic [15:0] w_sum;
   logic [15:0] w_acc_nx;
   logic [15:0] w_mplr_sh;
   logic        w_last;
   logic        w_accept;

   add16 u_add (
      .i_a   (r_acc),
      .i_b   (r_mcand),
      .o_sum (w_sum)
   );

   assign w_acc_nx  = r_mplr[0] ? w_sum : r_acc;
   assign w_mplr_sh = {1'b0, r_mplr[15:1]};
   assign w_accept  = start && (r_state != S_RUN);

   // Early exit looks at the multiplier after this step's shift
   assign w_last = (r_cnt == 5'd15)
                || (EARLY_EXIT && (w_mplr_sh == 16'h0000));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  w_next = start ? S_RUN : S_IDLE;
         S_RUN:   w_next = w_last ? S_DONE : S_RUN;
         S_DONE:  w_next = start ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_acc   <= '0;
         r_mcand <= '0;
         r_mplr  <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_acc   <= '0;
            r_mcand <= a;
            r_mplr  <= b;
            r_cnt   <= '0;
         end else if (r_state == S_RUN) begin
            r_acc   <= w_acc_nx;
            r_mcand <= {r_mcand[14:0], 1'b0};
            r_mplr  <= w_mplr_sh;
            r_cnt   <= r_cnt + 5'd1;
            if (w_last) begin
               r_out <= w_acc_nx;
            end
         end
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign out  = r_out;

endmodule

// File: tb/tb_mul16_seq.sv
// Scoreboard bench for mul16_seq: fixed-latency and early-exit instances,
// driven in separate phases and checked by a per-cycle monitor.

module tb_mul16_seq;

   typedef struct {
      int          dut;
      logic [15:0] prod;
      int          st;
      int          dn;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start_s [2];
   logic [15:0] a_s [2];
   logic [15:0] b_s [2];
   logic        busy_w [2];
   logic        done_w [2];
   logic [15:0] out_w [2];

   exp_t        q[$];
   logic [15:0] exp_out [2];
   logic        prev_done [2];
   int          cyc = 0;
   int          checks = 0;
   int          passed = 0;

   mul16_seq #(.EARLY_EXIT(1'b0)) u_dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s[0]),
      .a     (a_s[0]),
      .b     (b_s[0]),
      .busy  (busy_w[0]),
      .done  (done_w[0]),
      .out   (out_w[0])
   );

   mul16_seq #(.EARLY_EXIT(1'b1)) u_dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s[1]),
      .a     (a_s[1]),
      .b     (b_s[1]),
      .busy  (busy_w[1]),
      .done  (done_w[1]),
      .out   (out_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int d,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h",
                    nm, d, cyc, act, exp);
   endtask

   function automatic logic [15:0] ref_prod(input logic [15:0] x,
                                            input logic [15:0] y);
      logic [31:0] p;
      p = {16'h0, x} * {16'h0, y};
      return p[15:0];
   endfunction

   // Run length: 16 fixed, or position of the multiplier's top set bit
   function automatic int ref_k(input int d, input logic [15:0] y);
      int hb;
      if (d == 0) return 16;
      hb = 0;
      for (int i = 0; i < 16; i++) if (y[i]) hb = i + 1;
      return (hb < 1) ? 1 : hb;
   endfunction

   task automatic mon(input int d);
      logic has;
      logic exp_bz;
      has = (q.size() > 0) && (q[0].dut == d);
      exp_bz = has && (cyc >= q[0].st) && (cyc < q[0].dn);
      chk("busy", d, {31'b0, busy_w[d]}, {31'b0, exp_bz});
      if (prev_done[d] && done_w[d])
         chk("done_single", d, 32'd1, 32'd0);
      if (done_w[d]) begin
         if (!has) begin
            chk("unexpected_done", d, 32'd1, 32'd0);
         end else begin
            chk("done_cycle", d, cyc, q[0].dn);
            chk("product", d, {16'b0, out_w[d]}, {16'b0, q[0].prod});
            exp_out[d] = q[0].prod;
            void'(q.pop_front());
         end
      end else begin
         chk("out_hold", d, {16'b0, out_w[d]}, {16'b0, exp_out[d]});
         if (has && cyc >= q[0].dn) begin
            chk("missing_done", d, 32'd0, 32'd1);
            exp_out[d] = q[0].prod;
            void'(q.pop_front());
         end
      end
      prev_done[d] = done_w[d];
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         for (int d = 0; d < 2; d++) mon(d);
      end
   end

   task automatic issue(input int d, input logic [15:0] av,
                        input logic [15:0] bv);
      exp_t e;
      while (q.size() != 0 && cyc < q[q.size()-1].dn) @(negedge clk);
      a_s[d] = av;
      b_s[d] = bv;
      start_s[d] = 1'b1;
      e.dut  = d;
      e.prod = ref_prod(av, bv);
      e.st   = cyc + 1;
      e.dn   = cyc + 1 + ref_k(d, bv);
      q.push_back(e);
      @(negedge clk);
      start_s[d] = 1'b0;
      a_s[d] = 16'($urandom);
      b_s[d] = 16'($urandom);
   endtask

   task automatic poke(input int d, input logic [15:0] av,
                       input logic [15:0] bv);
      a_s[d] = av;
      b_s[d] = bv;
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
      a_s[d] = 16'($urandom);
      b_s[d] = 16'($urandom);
   endtask

   // Async reset mid-run, with start held high while reset is low
   task automatic do_reset(input int d);
      #1 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_busy", i, {31'b0, busy_w[i]}, 32'd0);
         chk("rst_done", i, {31'b0, done_w[i]}, 32'd0);
         chk("rst_out", i, {16'b0, out_w[i]}, 32'd0);
         exp_out[i] = 16'h0;
         prev_done[i] = 1'b0;
      end
      q.delete();
      start_s[d] = 1'b1;
      a_s[d] = 16'h00FF;
      b_s[d] = 16'h00FF;
      repeat (2) @(negedge clk);
      start_s[d] = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      int w;
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0;
         a_s[d] = 16'h0;
         b_s[d] = 16'h0;
         exp_out[d] = 16'h0;
         prev_done[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("init_busy", d, {31'b0, busy_w[d]}, 32'd0);
         chk("init_done", d, {31'b0, done_w[d]}, 32'd0);
         chk("init_out", d, {16'b0, out_w[d]}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      issue(0, 16'd3, 16'd5);
      issue(0, 16'hFFFF, 16'hFFFF);
      issue(0, 16'h0100, 16'h0100);
      issue(0, 16'd7, 16'd9);
      repeat (4) @(negedge clk);
      poke(0, 16'd2, 16'd2);
      issue(0, 16'h1234, 16'h0002);
      issue(0, 16'd0, 16'd0);
      repeat (20) @(negedge clk);

      issue(0, 16'hABCD, 16'h1357);
      repeat (7) @(negedge clk);
      do_reset(0);
      issue(0, 16'h0031, 16'h0107);

      for (int i = 0; i < 30; i++) begin
         issue(0, 16'($urandom), 16'($urandom));
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end

      issue(1, 16'h1234, 16'h0000);
      issue(1, 16'h1234, 16'h0001);
      issue(1, 16'h0003, 16'h8000);
      issue(1, 16'hFFFF, 16'hFFFF);
      for (int i = 0; i < 1000; i++) begin
         w = $urandom_range(0, 16);
         ra = 16'($urandom);
         rb = 16'($urandom & ((32'd1 << w) - 32'd1));
         issue(1, ra, rb);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      for (int i = 0; i < 40 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) chk("drain_timeout", 0, q.size(), 32'd0);
      @(negedge clk);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/mul16_seq.md
MUL16_SEQ -- requirements
Module: mul16_seq

Interface
REQ-001 Parameter EARLY_EXIT, default 0, meaning: 1 ends RUN as soon as the remaining multiplier is zero; 0 gives a fixed 16 RUN cycles.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005 a  input  16  multiplicand; captured only when start is accepted.
REQ-006 b  input  16  multiplier; captured only when start is accepted.
REQ-007 busy  output  1  high while the FSM is in RUN.
REQ-008 done  output  1  one-cycle pulse; out is valid in that cycle.
REQ-009 out  output  16  product modulo 2^16.

Function
REQ-010 The block SHALL contain exactly one 16-bit ripple adder instance (Add16, carry-in 0, carry-out discarded), and all accumulation SHALL go through that adder.
REQ-011 Internal state SHALL be:
- FSM state: IDLE, RUN or DONE
- acc[15:0]
- mcand[15:0]
- mplr[15:0]
- cnt[4:0]
REQ-012 IDLE or DONE with start=1 SHALL act as follows:
- capture mcand<=a, mplr<=b, acc<=0, cnt<=0
- go to RUN
REQ-013 IDLE with start=0 SHALL stay in IDLE.
REQ-014 DONE with start=0 SHALL go to IDLE.
REQ-015 Each RUN cycle SHALL perform one step:
- acc <= mplr[0] ? acc+mcand (via adder) : acc
- mcand <= mcand<<1, zero fill
- mplr <= mplr>>1, zero fill
- cnt <= cnt+1
REQ-016 With EARLY_EXIT=0, RUN SHALL go to DONE on the step where cnt==15, giving exactly 16 RUN cycles.
REQ-017 With EARLY_EXIT=1, RUN SHALL go to DONE on the first step where the shifted mplr is zero or cnt==15, giving 1..16 RUN cycles.
REQ-018 RUN SHALL never be skipped, including when b==0.
REQ-019 Latency: with start accepted at edge N and EARLY_EXIT=0, done SHALL be high in the cycle after edge N+16.
REQ-020 With EARLY_EXIT=1, latency SHALL be N+k, where k = max(1, index of highest set bit of b + 1).
REQ-021 On the edge entering DONE, out SHALL load the final acc; out SHALL then hold until the next DONE entry or reset.
REQ-022 done SHALL equal (state==DONE), and busy SHALL equal (state==RUN); both are registered-state decodes with no combinational path from start.
REQ-023 start while in RUN SHALL be ignored; a, b and the operation in flight SHALL be unaffected.
REQ-024 start in the DONE cycle SHALL be accepted, allowing back-to-back operations with one done cycle between them.
REQ-025 Arithmetic SHALL be unsigned; overflow bits above bit 15 SHALL be silently discarded.
REQ-026 Because the product is taken modulo 2^16, the same out bits SHALL also be correct for two's-complement operands.
REQ-027 Changes to a or b outside the accepting edge SHALL have no effect on the result.

Reset
REQ-028 rst_n low SHALL immediately, without waiting for a clock edge, force the following, regardless of state:
- state=IDLE
- busy=0, done=0, out=0
- acc=0, mcand=0, mplr=0, cnt=0
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-030 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which rst_n is high.
REQ-031 start sampled while rst_n is low SHALL be ignored.

Verification
REQ-032 EARLY_EXIT=0, a=3, b=5, start at edge 0 -> busy high for cycles 1..16; done pulse after edge 16; out=0x000F.
REQ-033 a=0xFFFF, b=0xFFFF -> out=0x0001. a=0x0100, b=0x0100 -> out=0x0000 (overflow discarded).
REQ-034 Start a=7, b=9; pulse start with a=2, b=2 at cycle 5 -> second start ignored; out=0x003F; single done pulse.
REQ-035 Assert rst_n low at cycle 8 of RUN -> busy=0 and out=0 asynchronously; no done pulse; a new start after release gives a correct product.
REQ-036 Start in the done cycle with a=0x1234, b=0x0002 -> new RUN begins next cycle; second done gives out=0x2468.
REQ-037 EARLY_EXIT=1 with each of b=0, b=1, b=0x8000 -> done after 1, 1 and 16 RUN cycles respectively; products correct against a reference model over 1000 random pairs.
